sparse_coo_sched: RTL and testbench

Sequencer for the sparse COO matrix-multiply datapath. Walks every (A entry, B entry) pair of two COO operand tables and finds the matching ones, where A column equals B row and both entries are valid. For each match it issues one multiply-accumulate request (A index, B index, C row, C column) to the FP8 E4M3 MAC/accumulator array over a valid/ready handshake. It clears the 8x8 FP32 C accumulators at job start and reports job completion. It sits between the job-control logic and the entry tables/MAC array.

---
 rtl/sparse_coo_sched.sv | 140 ++++++++++++++
 tb/tb_sparse_coo_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_coo_sched.sv
// COO pair sequencer: scans A x B entry pairs and issues a MAC request per column/row match, holding mac_valid until mac_ready.
// Busy = 1 + na*nb + matches + stalls cycles; `define SPARSE_SCHED_PERF_EN adds the stall_cnt output.
module sparse_coo_sched #(
   parameter int NNZ = 32,
   parameter int AW  = 5,
   parameter int IW  = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [AW:0]     nnz_a,
   input  logic [AW:0]     nnz_b,
   output logic            busy,
   output logic            done,
   output logic            acc_clr,
   output logic [AW-1:0]   a_addr,
   output logic [AW-1:0]   b_addr,
   input  logic [IW-1:0]   a_row,
   input  logic [IW-1:0]   a_col,
   input  logic [IW-1:0]   b_row,
   input  logic [IW-1:0]   b_col,
   input  logic            a_valid,
   input  logic            b_valid,
   output logic            mac_valid,
   input  logic            mac_ready,
   output logic [AW-1:0]   mac_a_idx,
   output logic [AW-1:0]   mac_b_idx,
   output logic [IW-1:0]   mac_c_row,
   output logic [IW-1:0]   mac_c_col,
   output logic [2*AW:0]   pair_cnt
`ifdef SPARSE_SCHED_PERF_EN
   ,
   output logic [15:0]     stall_cnt
`endif
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_SCAN  = 3'd2;
   localparam logic [2:0] S_ISSUE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [AW:0]   NNZ_W  = (AW+1)'(NNZ);
   localparam logic [AW:0]   CNT_1  = (AW+1)'(1);
   localparam logic [AW-1:0] IDX_1  = AW'(1);
   localparam logic [2*AW:0] PAIR_1 = (2*AW+1)'(1);

   logic [2:0]    state;
   logic [AW:0]   na, nb;
   logic [AW:0]   na_clamp, nb_clamp;
   logic [AW-1:0] i, j;
   logic [AW-1:0] i_adv, j_adv;
   logic          i_last, j_last, scan_end, match;

   always_comb begin
      na_clamp = (nnz_a > NNZ_W) ? NNZ_W : nnz_a;
      nb_clamp = (nnz_b > NNZ_W) ? NNZ_W : nnz_b;
      i_last   = ({1'b0, i} == (na - CNT_1));
      j_last   = ({1'b0, j} == (nb - CNT_1));
      scan_end = i_last & j_last;
      // Row-major walk: B index is the inner loop.
      j_adv    = j_last ? '0 : (j + IDX_1);
      i_adv    = j_last ? (i + IDX_1) : i;
      match    = a_valid & b_valid & (a_col == b_row);
   end

   assign busy      = (state == S_CLEAR) | (state == S_SCAN) | (state == S_ISSUE);
   assign done      = (state == S_DONE);
   assign acc_clr   = (state == S_CLEAR);
   assign mac_valid = (state == S_ISSUE);
   assign a_addr    = i;
   assign b_addr    = j;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         na        <= '0;
         nb        <= '0;
         i         <= '0;
         j         <= '0;
         mac_a_idx <= '0;
         mac_b_idx <= '0;
         mac_c_row <= '0;
         mac_c_col <= '0;
         pair_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  na       <= na_clamp;
                  nb       <= nb_clamp;
                  i        <= '0;
                  j        <= '0;
                  pair_cnt <= '0;
                  state    <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               state <= ((na == '0) || (nb == '0)) ? S_DONE : S_SCAN;
            end
            S_SCAN: begin
               if (match) begin
                  mac_a_idx <= i;
                  mac_b_idx <= j;
                  mac_c_row <= a_row;
                  mac_c_col <= b_col;
                  state     <= S_ISSUE;
               end else begin
                  i     <= i_adv;
                  j     <= j_adv;
                  state <= scan_end ? S_DONE : S_SCAN;
               end
            end
            S_ISSUE: begin
               if (mac_ready) begin
                  pair_cnt <= pair_cnt + PAIR_1;
                  i        <= i_adv;
                  j        <= j_adv;
                  state    <= scan_end ? S_DONE : S_SCAN;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef SPARSE_SCHED_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if ((state == S_IDLE) && start) begin
         stall_cnt <= '0;
      end else if (mac_valid && !mac_ready && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sparse_coo_sched.sv
// Bench for sparse_coo_sched: pair-list reference model, per-cycle request monitor and job-level timing checks.
module tb_sparse_coo_sched;
   localparam int NNZ = 32;
   localparam int AW  = 5;
   localparam int IW  = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [AW:0]     nnz_a = '0, nnz_b = '0;
   logic            busy, done, acc_clr;
   logic [AW-1:0]   a_addr, b_addr;
   logic [IW-1:0]   a_row, a_col, b_row, b_col;
   logic            a_valid, b_valid;
   logic            mac_valid;
   logic            mac_ready = 1'b1;
   logic [AW-1:0]   mac_a_idx, mac_b_idx;
   logic [IW-1:0]   mac_c_row, mac_c_col;
   logic [2*AW:0]   pair_cnt;
`ifdef SPARSE_SCHED_PERF_EN
   logic [15:0]     stall_cnt;
`endif

   logic [IW-1:0] ta_row [NNZ];
   logic [IW-1:0] ta_col [NNZ];
   logic [IW-1:0] tb_row [NNZ];
   logic [IW-1:0] tb_col [NNZ];
   logic          ta_v   [NNZ];
   logic          tb_v   [NNZ];

   assign a_row   = ta_row[a_addr];
   assign a_col   = ta_col[a_addr];
   assign a_valid = ta_v[a_addr];
   assign b_row   = tb_row[b_addr];
   assign b_col   = tb_col[b_addr];
   assign b_valid = tb_v[b_addr];

   sparse_coo_sched #(.NNZ(NNZ), .AW(AW), .IW(IW)) dut (
      .clk(clk), .rst(rst), .start(start), .nnz_a(nnz_a), .nnz_b(nnz_b),
      .busy(busy), .done(done), .acc_clr(acc_clr), .a_addr(a_addr), .b_addr(b_addr),
      .a_row(a_row), .a_col(a_col), .b_row(b_row), .b_col(b_col),
      .a_valid(a_valid), .b_valid(b_valid), .mac_valid(mac_valid), .mac_ready(mac_ready),
      .mac_a_idx(mac_a_idx), .mac_b_idx(mac_b_idx), .mac_c_row(mac_c_row), .mac_c_col(mac_c_col),
      .pair_cnt(pair_cnt)
`ifdef SPARSE_SCHED_PERF_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { int a; int b; int r; int c; } req_t;
   req_t exp_q[$];
   int   exp_na, exp_nb;
   int   n_chk = 0, n_pass = 0, cyc = 0;
   bit   mon_en = 1'b0;
   int   n_clr, clr_cyc, n_busy, n_done, done_cyc, n_req, n_stall, max_a;
   int   rdy_mode = 0, stall_left = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [31:0] pk(input int a, input int b, input int r, input int c);
      return 32'((a << 11) | (b << 6) | (r << 3) | c);
   endfunction

   // Reference: every (i,j) pair in row-major order, one request per valid column/row match.
   function automatic int build_model(input int na_in, input int nb_in);
      req_t e;
      exp_na = (na_in > NNZ) ? NNZ : na_in;
      exp_nb = (nb_in > NNZ) ? NNZ : nb_in;
      exp_q.delete();
      for (int i = 0; i < exp_na; i++)
         for (int j = 0; j < exp_nb; j++)
            if (ta_v[i] && tb_v[j] && (ta_col[i] == tb_row[j])) begin
               e.a = i; e.b = j; e.r = int'(ta_row[i]); e.c = int'(tb_col[j]);
               exp_q.push_back(e);
            end
      return exp_q.size();
   endfunction

   task automatic load_ref();
      for (int i = 0; i < NNZ; i++) begin
         ta_row[i] = IW'($urandom_range(0, 7)); ta_col[i] = IW'($urandom_range(0, 7)); ta_v[i] = 1'b0;
         tb_row[i] = IW'($urandom_range(0, 7)); tb_col[i] = IW'($urandom_range(0, 7)); tb_v[i] = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         ta_row[i] = IW'(i / 3); ta_col[i] = IW'(i % 3); ta_v[i] = 1'b1;
      end
      for (int j = 0; j < 4; j++) begin
         tb_row[j] = IW'(j); tb_col[j] = IW'(j); tb_v[j] = 1'b1;
      end
   endtask

   task automatic load_random();
      for (int i = 0; i < NNZ; i++) begin
         ta_row[i] = IW'($urandom_range(0, 7)); ta_col[i] = IW'($urandom_range(0, 3));
         ta_v[i]   = ($urandom_range(0, 4) != 0);
         tb_row[i] = IW'($urandom_range(0, 3)); tb_col[i] = IW'($urandom_range(0, 7));
         tb_v[i]   = ($urandom_range(0, 4) != 0);
      end
   endtask

   // mac_ready driver: 0 = always ready, 1 = first three valid cycles stalled, 2 = random.
   initial forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0: mac_ready = 1'b1;
         1: if (mac_valid && stall_left > 0) begin
               mac_ready = 1'b0;
               stall_left--;
            end else mac_ready = 1'b1;
         default: mac_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (acc_clr) begin n_clr++; clr_cyc = cyc; end
         if (done) begin n_done++; done_cyc = cyc; end
         if (busy) begin
            n_busy++;
            if (int'(a_addr) > max_a) max_a = int'(a_addr);
            if (!acc_clr && exp_na > 0 && exp_nb > 0) begin
               chk("a_addr_range", 32'(int'(a_addr) < exp_na), 32'd1);
               chk("b_addr_range", 32'(int'(b_addr) < exp_nb), 32'd1);
            end
         end
         if (mac_valid) begin
            chk("req_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               chk("req_payload", 32'({mac_a_idx, mac_b_idx, mac_c_row, mac_c_col}),
                   pk(exp_q[0].a, exp_q[0].b, exp_q[0].r, exp_q[0].c));
               if (mac_ready) begin
                  void'(exp_q.pop_front());
                  n_req++;
               end
            end
            if (!mac_ready) n_stall++;
         end
      end
   end

   task automatic run_job(input string tag, input int na_in, input int nb_in, input int mode, input bit mid_start);
      int k, nm, exp_st, exp_busy;
      bit got;
      nm = build_model(na_in, nb_in);
      rdy_mode = mode;
      stall_left = (mode == 1) ? 3 : 0;
      n_clr = 0; n_busy = 0; n_done = 0; n_req = 0; n_stall = 0; max_a = 0;
      clr_cyc = -1; done_cyc = -1;
      mon_en = 1'b1;
      @(negedge clk);
      nnz_a = (AW+1)'(na_in); nnz_b = (AW+1)'(nb_in); start = 1'b1;
      @(posedge clk);
      #1;
      k = cyc;
      start = 1'b0;
      nnz_a = (AW+1)'($urandom_range(0, 63)); nnz_b = (AW+1)'($urandom_range(0, 63));
      got = 1'b0;
      for (int t = 0; t < 6000 && !got; t++) begin
         @(negedge clk);
         if (mid_start && t == 4) begin nnz_a = 6'd3; nnz_b = 6'd3; start = 1'b1; end
         if (mid_start && t == 5) start = 1'b0;
         if (done) got = 1'b1;
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
      repeat (2) @(negedge clk);
      mon_en = 1'b0;
      exp_st = (mode == 0) ? 0 : (mode == 1) ? ((nm > 0) ? 3 : 0) : n_stall;
      if (mode != 2) chk({tag, "_stalls"}, 32'(n_stall), 32'(exp_st));
      exp_busy = 1 + exp_na * exp_nb + nm + exp_st;
      chk({tag, "_acc_clr_cnt"}, 32'(n_clr), 32'd1);
      chk({tag, "_acc_clr_cyc"}, 32'(clr_cyc), 32'(k));
      chk({tag, "_busy_len"}, 32'(n_busy), 32'(exp_busy));
      chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(k + exp_busy));
      chk({tag, "_done_cnt"}, 32'(n_done), 32'd1);
      chk({tag, "_req_cnt"}, 32'(n_req), 32'(nm));
      chk({tag, "_req_left"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_pair_cnt"}, 32'(pair_cnt), 32'(nm));
      chk({tag, "_max_a_addr"}, 32'(max_a), 32'((exp_na * exp_nb > 0) ? exp_na - 1 : 0));
`ifdef SPARSE_SCHED_PERF_EN
      chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(n_stall));
`endif
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_acc_clr"}, 32'(acc_clr), 32'd0);
      chk({tag, "_mac_valid"}, 32'(mac_valid), 32'd0);
      chk({tag, "_pair_cnt"}, 32'(pair_cnt), 32'd0);
      chk({tag, "_addr"}, 32'({a_addr, b_addr}), 32'd0);
      chk({tag, "_payload"}, 32'({mac_a_idx, mac_b_idx, mac_c_row, mac_c_col}), 32'd0);
   endtask

   initial begin
      int nm;
      load_ref();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_idle_outputs("por");
      rst = 1'b0;

      // Hand-derived expectations for the reference tables pin the model.
      nm = build_model(8, 4);
      chk("model_ref_cnt", 32'(nm), 32'd8);
      chk("model_ref_first", pk(exp_q[0].a, exp_q[0].b, exp_q[0].r, exp_q[0].c), pk(0, 0, 0, 0));
      chk("model_ref_last", pk(exp_q[7].a, exp_q[7].b, exp_q[7].r, exp_q[7].c), pk(7, 1, 2, 1));
      nm = build_model(40, 1);
      chk("model_clamp_na", 32'(exp_na), 32'd32);

      run_job("ref", 8, 4, 0, 1'b0);
      run_job("bp", 8, 4, 1, 1'b0);

      // Reset in the middle of a job.
      rdy_mode = 0;
      @(negedge clk);
      nnz_a = 6'd8; nnz_b = 6'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_idle_outputs("midrst");
      run_job("after_rst", 8, 4, 0, 1'b0);

      run_job("empty_b", 8, 0, 0, 1'b0);
      for (int j = 0; j < 4; j++) tb_v[j] = 1'b0;
      run_job("b_invalid", 8, 4, 0, 1'b0);
      for (int j = 0; j < 4; j++) tb_v[j] = 1'b1;
      run_job("start_busy", 8, 4, 0, 1'b1);

      load_random();
      run_job("clamp", 40, 1, 2, 1'b0);
      for (int n = 0; n < 8; n++) begin
         load_random();
         run_job("rnd", $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 2), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end
endmodule
